// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the iterative 32-bit MIPS DIV/DIVU divider.
// Latches the operands on acceptance, runs the divider start/annul handshake,
// stalls the pipeline while a divide is in flight, writes HI/LO on completion,
// and aborts through a drain phase on flush or watchdog timeout.
//
// Divider handshake: div_start_o is held high for the whole RUN phase, and the
// operands stay frozen on div_op*_o while it is high. The divider raises
// div_ready_i with a valid div_result_i and keeps it high for as long as
// div_start_o stays high. It drops ready once div_start_o falls. A
// div_annul_o pulse (with div_start_o low) kills the operation in progress.
module div_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TMO_W          = 6,
  parameter int DRAIN_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_div_req_i,
  input  logic        ex_div_signed_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Drain counter counts 0 .. DRAIN_CYCLES-1; at least one bit wide.
  localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [DRN_W-1:0] DRN_LAST =
    DRN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
  logic               div_signed_q, div_signed_d;
  logic [31:0]        div_op1_q, div_op1_d;
  logic [31:0]        div_op2_q, div_op2_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               hilo_we_q, hilo_we_d;
  logic               err_q, err_d;
  logic               stall_c;
  logic               start_c;
  logic               annul_c;

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tmo_cnt_q    <= '0;
      drn_cnt_q    <= '0;
      div_signed_q <= 1'b0;
      div_op1_q    <= '0;
      div_op2_q    <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      hilo_we_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      drn_cnt_q    <= drn_cnt_d;
      div_signed_q <= div_signed_d;
      div_op1_q    <= div_op1_d;
      div_op2_q    <= div_op2_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      hilo_we_q    <= hilo_we_d;
      err_q        <= err_d;
    end
  end

  // Next-state, counters and combinational handshake/stall outputs.
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    drn_cnt_d    = drn_cnt_q;
    div_signed_d = div_signed_q;
    div_op1_d    = div_op1_q;
    div_op2_d    = div_op2_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    hilo_we_d    = 1'b0;
    err_d        = 1'b0;
    stall_c      = 1'b0;
    start_c      = 1'b0;
    annul_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Flush wins over a request arriving in the same cycle.
        if (ex_div_req_i && !flush_i) begin
          div_signed_d = ex_div_signed_i;
          div_op1_d    = ex_op1_i;
          div_op2_d    = ex_op2_i;
          tmo_cnt_d    = '0;
          stall_c      = 1'b1;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        start_c   = 1'b1;
        stall_c   = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (flush_i) begin
          start_c   = 1'b0;
          annul_c   = 1'b1;
          stall_c   = 1'b0;
          drn_cnt_d = '0;
          state_d   = S_DRAIN;
        end else if (div_ready_i) begin
          // Release EX in the ready cycle; the write strobe follows next cycle.
          stall_c   = 1'b0;
          hi_d      = div_result_i[63:32];
          lo_d      = div_result_i[31:0];
          hilo_we_d = 1'b1;
          state_d   = S_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          start_c   = 1'b0;
          annul_c   = 1'b1;
          stall_c   = 1'b0;
          err_d     = 1'b1;
          drn_cnt_d = '0;
          state_d   = S_DRAIN;
        end
      end

      S_DONE: begin
        // A new request waits here until the divider has dropped ready.
        stall_c = ex_div_req_i;
        if (!div_ready_i) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        // Minimum dwell covers an abort landing in the divider's end states.
        stall_c = ex_div_req_i && !flush_i;
        if (drn_cnt_q != DRN_LAST) begin
          drn_cnt_d = drn_cnt_q + 1'b1;
        end else if (!div_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall is forced low while reset is asserted, whatever EX presents.
  assign stall_req_o  = rst_n & stall_c;
  assign div_start_o  = start_c;
  assign div_annul_o  = annul_c;
  assign hilo_we_o    = hilo_we_q;
  assign err_o        = err_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign div_signed_o = div_signed_q;
  assign div_op1_o    = div_op1_q;
  assign div_op2_o    = div_op2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider
// model, a HI/LO scoreboard and scenario tasks run in sequence.
module tb_div_ctrl;

  localparam int TIMEOUT_CYCLES = 40;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        ex_div_req_i;
  logic        ex_div_signed_i;
  logic [31:0] ex_op1_i;
  logic [31:0] ex_op2_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        err_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  div_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_W(6),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_div_req_i(ex_div_req_i),
    .ex_div_signed_i(ex_div_signed_i),
    .ex_op1_i(ex_op1_i),
    .ex_op2_i(ex_op2_i),
    .flush_i(flush_i),
    .stall_req_o(stall_req_o),
    .hilo_we_o(hilo_we_o),
    .hi_o(hi_o),
    .lo_o(lo_o),
    .err_o(err_o),
    .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o),
    .div_op2_o(div_op2_o),
    .div_start_o(div_start_o),
    .div_annul_o(div_annul_o),
    .div_result_i(div_result_i),
    .div_ready_i(div_ready_i)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int err_cnt  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  // Reference arithmetic: {remainder, quotient}; divide by zero gives 0/0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // ---------------- divider model ----------------
  // Counts start cycles, raises ready after lat cycles (2 for a zero divisor)
  // and holds it while start stays high; never_ready models a hung divider.
  bit          never_ready = 1'b0;
  int          lat = 36;
  logic        mdl_rdy;
  logic [63:0] mdl_res;
  int          mdl_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_rdy <= 1'b0;
      mdl_res <= '0;
      mdl_cnt <= 0;
    end else if (div_start_o) begin
      if (!mdl_rdy) begin
        mdl_cnt <= mdl_cnt + 1;
        if (!never_ready && (mdl_cnt + 1 >= ((div_op2_o == 32'd0) ? 2 : lat))) begin
          mdl_rdy <= 1'b1;
          mdl_res <= ref_div(div_signed_o, div_op1_o, div_op2_o);
        end
      end
    end else begin
      mdl_rdy <= 1'b0;
      mdl_cnt <= 0;
    end
  end

  assign div_ready_i  = mdl_rdy;
  assign div_result_i = mdl_res;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (hilo_we_o === 1'b1) begin
      we_cnt = we_cnt + 1;
      got_q.push_back({hi_o, lo_o});
    end
    if (err_o === 1'b1) err_cnt = err_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a request and follows it until stall drops. Returns the stalled
  // cycles before the divider starts, the start cycles, operand stability,
  // and ready/annul as seen in the cycle the stall released.
  task automatic issue_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit expect_wr, input logic [63:0] exp_v,
                           output int waits, output int runs, output bit stable,
                           output bit brk_ready, output bit brk_annul);
    bit timed_out;
    ex_div_signed_i = sgn;
    ex_op1_i        = a;
    ex_op2_i        = b;
    ex_div_req_i    = 1'b1;
    if (expect_wr) exp_q.push_back(exp_v);
    waits = 0; runs = 0; stable = 1'b1; brk_ready = 1'b0; brk_annul = 1'b0;
    timed_out = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (div_start_o) begin
        runs++;
        if ({div_signed_o, div_op1_o, div_op2_o} !== {sgn, a, b}) stable = 1'b0;
      end else if (runs == 0 && stall_req_o) begin
        waits++;
      end else if (stall_req_o) begin
        stable = 1'b0;
      end
      if (!stall_req_o) begin
        brk_ready = div_ready_i;
        brk_annul = div_annul_o;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
    n_checks++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL issue_bound: stall still high after 200 cycles (op1=%0h op2=%0h)", a, b);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; ex_div_req_i = 1'b1; ex_div_signed_i = 1'b1;
    ex_op1_i = 32'h1234_5678; ex_op2_i = 32'h9; flush_i = 1'b0;
    idle(2); #1;
    n_checks++;
    if (stall_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_req_o);
    end
    n_checks++;
    if ({hilo_we_o, err_o, div_start_o, div_annul_o, div_signed_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {hilo_we_o, err_o, div_start_o, div_annul_o, div_signed_o});
    end
    n_checks++;
    if ({hi_o, lo_o, div_op1_o, div_op2_o} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: got hi=%0h lo=%0h op1=%0h op2=%0h expected all 0",
               hi_o, lo_o, div_op1_o, div_op2_o);
    end
    @(negedge clk);
    rst_n = 1'b1; ex_div_req_i = 1'b0;
    idle(2);
  endtask

  task automatic test_divu_basic();
    int w, r, we0, err0; bit st, br, ba;
    logic [63:0] e, g;
    we0 = we_cnt; err0 = err_cnt; lat = 33;
    issue_div(1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, w, r, st, br, ba);
    n_checks++;
    if (w != 1) begin n_fail++; $display("FAIL divu_wait: got %0d expected 1", w); end
    n_checks++;
    if (r != lat + 1) begin n_fail++; $display("FAIL divu_start_cycles: got %0d expected %0d", r, lat + 1); end
    n_checks++;
    if (br !== 1'b1) begin n_fail++; $display("FAIL divu_stall_drop: ready=%b at stall release expected 1", br); end
    @(negedge clk); ex_div_req_i = 1'b0; #1;
    n_checks++;
    if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'd2, 32'd14}) begin
      n_fail++; $display("FAIL divu_write: got we=%b hi=%0d lo=%0d expected we=1 hi=2 lo=14", hilo_we_o, hi_o, lo_o);
    end
    idle(4);
    n_checks++;
    if (we_cnt - we0 != 1 || err_cnt != err0) begin
      n_fail++; $display("FAIL divu_strobes: got we=%0d err=%0d expected we=1 err=0", we_cnt - we0, err_cnt - err0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL divu_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_div_signed();
    int w, r, we0; bit st, br, ba;
    logic [63:0] e, g;
    we0 = we_cnt; lat = $urandom_range(30, 36);
    issue_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, w, r, st, br, ba);
    n_checks++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL signed_ops_stable: got %b expected 1", st); end
    @(negedge clk); ex_div_req_i = 1'b0;
    idle(4);
    n_checks++;
    if (we_cnt - we0 != 1) begin n_fail++; $display("FAIL signed_strobes: got %0d expected 1", we_cnt - we0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL signed_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_div_zero();
    int w, r, we0, err0; bit st, br, ba;
    logic [63:0] e, g;
    we0 = we_cnt; err0 = err_cnt; lat = 36;
    issue_div(1'b0, 32'd5, 32'd0, 1'b1, 64'd0, w, r, st, br, ba);
    n_checks++;
    if (r != 3) begin n_fail++; $display("FAIL zero_start_cycles: got %0d expected 3", r); end
    @(negedge clk); ex_div_req_i = 1'b0;
    idle(4);
    n_checks++;
    if (we_cnt - we0 != 1 || err_cnt != err0) begin
      n_fail++; $display("FAIL zero_strobes: got we=%0d err=%0d expected we=1 err=0", we_cnt - we0, err_cnt - err0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL zero_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_flush();
    int w, r, we0, runs; bit st, br, ba, to;
    logic [63:0] e, g;
    we0 = we_cnt; lat = 36; runs = 0; to = 1'b1;
    ex_div_signed_i = 1'b0; ex_op1_i = 32'd1000; ex_op2_i = 32'd3; ex_div_req_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (div_start_o) runs++;
      if (runs == 10) begin to = 1'b0; break; end
    end
    n_checks++;
    if (to) begin n_fail++; $display("FAIL flush_run_bound: only %0d start cycles seen", runs); end
    @(negedge clk); flush_i = 1'b1; #1;
    n_checks++;
    if ({div_annul_o, div_start_o, stall_req_o} !== 3'b100) begin
      n_fail++; $display("FAIL flush_handshake: got annul/start/stall=%b expected 100",
                         {div_annul_o, div_start_o, stall_req_o});
    end
    @(negedge clk); flush_i = 1'b0;
    issue_div(1'b0, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3}, w, r, st, br, ba);
    n_checks++;
    if (w != 3) begin n_fail++; $display("FAIL flush_drain_wait: got %0d expected 3", w); end
    @(negedge clk); ex_div_req_i = 1'b0;
    idle(4);
    n_checks++;
    if (we_cnt - we0 != 1) begin n_fail++; $display("FAIL flush_strobes: got %0d expected 1", we_cnt - we0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL flush_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    int w, r, we0; bit st, br, ba;
    logic [63:0] e, g;
    we0 = we_cnt; lat = $urandom_range(30, 36);
    issue_div(1'b0, 32'd8, 32'd2, 1'b1, {32'd0, 32'd4}, w, r, st, br, ba);
    @(negedge clk);
    issue_div(1'b0, 32'd9, 32'd4, 1'b1, {32'd1, 32'd2}, w, r, st, br, ba);
    n_checks++;
    if (w != 3) begin n_fail++; $display("FAIL b2b_second_wait: got %0d expected 3", w); end
    @(negedge clk); ex_div_req_i = 1'b0;
    idle(4);
    n_checks++;
    if (we_cnt - we0 != 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 2", we_cnt - we0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_timeout();
    int w, r, we0, err0; bit st, br, ba;
    we0 = we_cnt; err0 = err_cnt; never_ready = 1'b1; lat = 36;
    issue_div(1'b0, 32'd123, 32'd4, 1'b0, 64'd0, w, r, st, br, ba);
    n_checks++;
    if (r != TIMEOUT_CYCLES - 1) begin
      n_fail++; $display("FAIL tmo_start_cycles: got %0d expected %0d", r, TIMEOUT_CYCLES - 1);
    end
    n_checks++;
    if ({ba, br} !== 2'b10) begin n_fail++; $display("FAIL tmo_annul: got annul/ready=%b expected 10", {ba, br}); end
    @(negedge clk); ex_div_req_i = 1'b0; #1;
    n_checks++;
    if ({err_o, hilo_we_o} !== 2'b10) begin n_fail++; $display("FAIL tmo_err_pulse: got err/we=%b expected 10", {err_o, hilo_we_o}); end
    @(negedge clk); #1;
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b expected 0", err_o); end
    idle(4);
    n_checks++;
    if (err_cnt - err0 != 1 || we_cnt != we0) begin
      n_fail++; $display("FAIL tmo_counts: got err=%0d we=%0d expected err=1 we=0", err_cnt - err0, we_cnt - we0);
    end
    never_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w, r, we0, runs; bit st, br, ba, to;
    logic [63:0] e, g;
    lat = 36; runs = 0; to = 1'b1;
    ex_div_signed_i = 1'b1; ex_op1_i = 32'd77; ex_op2_i = 32'd5; ex_div_req_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (div_start_o) runs++;
      if (runs == 5) begin to = 1'b0; break; end
    end
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rstmid_run_bound: only %0d start cycles seen", runs); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_checks++;
    if ({stall_req_o, hilo_we_o, err_o, div_start_o, div_annul_o, div_signed_o} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b expected 000000",
                         {stall_req_o, hilo_we_o, err_o, div_start_o, div_annul_o, div_signed_o});
    end
    n_checks++;
    if ({hi_o, lo_o, div_op1_o, div_op2_o} !== 128'b0) begin
      n_fail++; $display("FAIL rstmid_data: got hi=%0h lo=%0h op1=%0h op2=%0h expected all 0",
                         hi_o, lo_o, div_op1_o, div_op2_o);
    end
    @(negedge clk); rst_n = 1'b1; ex_div_req_i = 1'b0;
    idle(2);
    we0 = we_cnt;
    issue_div(1'b0, 32'd77, 32'd5, 1'b1, {32'd2, 32'd15}, w, r, st, br, ba);
    n_checks++;
    if (w != 1) begin n_fail++; $display("FAIL rstmid_recover_wait: got %0d expected 1", w); end
    @(negedge clk); ex_div_req_i = 1'b0;
    idle(4);
    n_checks++;
    if (we_cnt - we0 != 1) begin n_fail++; $display("FAIL rstmid_strobes: got %0d expected 1", we_cnt - we0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rstmid_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_random();
    int w, r, we0; bit st, br, ba;
    logic sgn; logic [31:0] a, b;
    logic [63:0] e, g;
    we0 = we_cnt;
    for (int k = 0; k < 8; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat = $urandom_range(28, 36);
      issue_div(sgn, a, b, 1'b1, ref_div(sgn, a, b), w, r, st, br, ba);
      n_checks++;
      if (st !== 1'b1) begin n_fail++; $display("FAIL rand_ops_stable[%0d]: got %b expected 1", k, st); end
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        ex_div_req_i = 1'b0;
        idle($urandom_range(0, 3));
      end
    end
    ex_div_req_i = 1'b0;
    idle(5);
    n_checks++;
    if (we_cnt - we0 != 8) begin n_fail++; $display("FAIL rand_strobes: got %0d expected 8", we_cnt - we0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rand_sb: got %016h expected %016h", g, e); end
    end
    got_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-stage sequencer for the iterative 32-bit divider used by MIPS DIV/DIVU.
- Accepts a divide request from EX, latches the operands and holds them stable for the whole operation.
- Drives the divider start/annul handshake and stalls the pipeline until the result is ready.
- Writes quotient/remainder to HI/LO; handles pipeline flush and a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 40, max cycles in RUN without div_ready_i before forced abort (nominal divide completes in ~36)
TMO_W, 6, width of timeout counter; must hold TIMEOUT_CYCLES
DRAIN_CYCLES, 2, minimum cycles spent in DRAIN after an abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
ex_div_req_i  in  1  EX holds a DIV/DIVU this cycle
ex_div_signed_i  in  1  1=DIV (signed), 0=DIVU
ex_op1_i  in  32  dividend
ex_op2_i  in  32  divisor
flush_i  in  1  pipeline flush/exception; kills current divide
stall_req_o  out  1  stall request to pipeline control (combinational)
hilo_we_o  out  1  one-cycle HI/LO write strobe
hi_o  out  32  remainder
lo_o  out  32  quotient
err_o  out  1  one-cycle pulse on watchdog abort
div_signed_o  out  1  to divider signed_div_i
div_op1_o  out  32  to divider opdata1_i (latched)
div_op2_o  out  32  to divider opdata2_i (latched)
div_start_o  out  1  to divider start_i (1=start, 0=stop)
div_annul_o  out  1  to divider annul_i
div_result_i  in  64  from divider: [63:32] remainder, [31:0] quotient
div_ready_i  in  1  from divider ready

Behaviour:
- Reset: all registers cleared; state=IDLE. All outputs are 0 in reset, including hi_o/lo_o/div_op*_o/div_signed_o; stall_req_o=0 in reset.
- States: IDLE, RUN, DONE, DRAIN. Encoding is free.
- IDLE:
  - If ex_div_req_i & ~flush_i: latch signed/op1/op2 into the div_*_o registers; stall_req_o=1 (comb); next=RUN; clear the timeout counter.
  - flush_i has priority over ex_div_req_i.
- RUN:
  - div_start_o=1; operands held constant (the divider re-reads them for sign correction); stall_req_o=1 unless leaving this cycle; the timeout counter increments each cycle.
  - Exit priority, highest first:
  - (1) flush_i: drive div_start_o=0 and div_annul_o=1 this cycle (combinational from state & flush_i); next=DRAIN; no HI/LO write.
  - (2) div_ready_i: capture hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0] at the clock edge; hilo_we_o=1 in the following cycle (registered); stall_req_o=0 in the ready cycle so EX advances; next=DONE.
  - (3) counter==TIMEOUT_CYCLES-1: div_start_o=0 and div_annul_o=1; err_o pulses the next cycle; stall_req_o=0; next=DRAIN; no HI/LO write.
- DONE:
  - div_start_o=0, so the divider returns to free and drops ready.
  - hilo_we_o=1 for exactly the first DONE cycle.
  - Stay while div_ready_i=1; next=IDLE when div_ready_i=0.
  - New ex_div_req_i here is not accepted; stall_req_o=ex_div_req_i.
- DRAIN:
  - div_start_o=0, div_annul_o=0.
  - Stay at least DRAIN_CYCLES and until div_ready_i=0. This covers an abort landing in the divider's by-zero/end states.
  - stall_req_o=ex_div_req_i & ~flush_i; then IDLE.
- Divide by zero: no special handling. The divider returns 0/0 and the controller writes HI=0, LO=0 as a normal completion.
- hi_o/lo_o hold their last written value until the next completion.
- A flush in DONE/DRAIN/IDLE has no effect beyond suppressing acceptance; a HI/LO write already in flight (DONE first cycle) still completes.
- Back-to-back divides: minimum spacing is RUN→DONE→IDLE→RUN. A second request waits stalled in DONE.
- Reset mid-operation: immediate return to IDLE, outputs 0. The divider shares rst_n, so no drain is needed.

Test Plan:
- DIVU 100/7: req 1 cycle-held with stall honoured → div_start_o high until ready; one hilo_we_o pulse with hi=2, lo=14; stall_req_o drops in the ready cycle.
- DIV -7/2 signed: → hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); div_op1_o/op2_o constant throughout RUN.
- DIVU 5/0: → completes quickly; hi=0, lo=0, hilo_we_o=1, err_o=0.
- flush_i 10 cycles into RUN: → div_annul_o=1 and div_start_o=0 that cycle; no hilo_we_o; DRAIN ≥2 cycles, then IDLE; a following DIVU 9/3 gives lo=3, hi=0.
- Back-to-back DIVU 8/2 then 9/4: → second stalled through DONE, then lo=4/hi=0 followed by lo=2/hi=1, exactly two write strobes.
- Divider model never asserts ready: → after 40 RUN cycles err_o pulses once, annul asserted, stall released, no HI/LO write; an rst_n pulse mid-RUN returns all outputs to 0.
